pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline control for the five-stage core. It merges the per-stage stall requests into the 6-bit `stall` vector consumed by pc_reg and every inter-stage register (if_id, id_ex, ex_mem, mem_wb). It sequences exception flushes, including deferral while the memory stage is waiting on the bus. It also keeps stall/flush statistics and a stall watchdog for debug.

## Interface
Parameters:
- `TIMEOUT`, 1024: consecutive stalled cycles after which `stall_timeout` sets.
- `CNT_W`, 32: width of `stall_cycles`.

Ports:
- `clk` input 1: core clock.
- `rst` input 1: reset, asynchronous, active-low.
- `stallreq_from_if` input 1: fetch not ready.
- `stallreq_from_id` input 1: load-use hazard.
- `stallreq_from_ex` input 1: multi-cycle ALU busy (div/madd).
- `stallreq_from_mem` input 1: data bus wait.
- `except_req` input 1: exception committed in MEM this cycle.
- `except_pc` input 32: handler address for `except_req`.
- `stall` output 6: bit0 pc, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB. 1 = Stop.
- `flush` output 1: clear all pipeline registers this cycle.
- `new_pc` output 32: redirect target, valid when `flush`=1.
- `stall_cycles` output CNT_W: count of cycles with `stall[0]`=1, saturating.
- `flush_count` output 16: number of flushes issued, wrapping.
- `stall_timeout` output 1: sticky watchdog flag.

## Operation
Stall merge (combinational, highest stage wins):
- mem → 6'b011111
- else ex → 6'b001111
- else id → 6'b000111
- else if → 6'b000011
- else 6'b000000
- `flush`=1 forces `stall`=6'b000000.

Flush FSM, states RUN and PEND:
- RUN, `except_req`=1, `stallreq_from_mem`=0: `flush`=1 and `new_pc`=`except_pc` in the same cycle; stay in RUN.
- RUN, `except_req`=1, `stallreq_from_mem`=1: latch `except_pc` into `pend_pc`; go to PEND. `flush`=0 and the stall merge continues normally.
- PEND, `stallreq_from_mem`=1: hold in PEND.
- PEND, `stallreq_from_mem`=0: `flush`=1 and `new_pc`=`pend_pc` combinationally; return to RUN.
- `except_req` while in PEND is ignored; the first exception wins.
- `new_pc`=0 whenever `flush`=0.

Counters:
- `stall_cycles` increments each cycle `stall[0]`=1; it saturates at all-ones.
- `flush_count` increments on each cycle `flush`=1; it wraps at 16 bits.
- Watchdog: internal counter `wd` increments while `stall[0]`=1 and clears otherwise. When `wd` reaches TIMEOUT-1 while stalled, `stall_timeout` sets on the next edge. It clears only on reset. `wd` saturates at TIMEOUT-1.

Reset (`rst`=0, asynchronous):
- State forced to RUN.
- `pend_pc`, `wd`, `stall_cycles`, `flush_count` and `stall_timeout` all return to 0.
- The combinational outputs follow from the inputs and the RUN state.
- A reset during PEND discards the pending exception; no flush is issued.

## Timing
- `stall`, `flush` and `new_pc` are combinational from inputs and state, so pipeline registers sample them at the same edge. There is zero-cycle latency from a request to the stall.
- Deferred flush: `flush` is asserted in the first cycle `stallreq_from_mem` is low after entering PEND. The minimum is 1 cycle after `except_req`.
- Counters, FSM and `pend_pc` update on `posedge clk`. Reset acts immediately on `negedge rst`.
- Watchdog: with `stall[0]` continuously 1 starting at cycle 0, `stall_timeout` reads 1 after edge TIMEOUT, i.e. after TIMEOUT stalled cycles.
- A single-cycle stall gap restarts the watchdog from 0.

## Test plan
- Priority: if, id, ex, mem requests all high → `stall`=6'b011111. Drop mem → 6'b001111. Drop ex → 6'b000111. Drop id → 6'b000011. Drop if → 0.
- Immediate flush: `except_req`=1, `except_pc`=0x00000380, no mem stall, with id stall high → same cycle `flush`=1, `new_pc`=0x380, `stall`=0. Next cycle `flush_count`=1.
- Deferred flush:
  - Stimulus: `except_req` pulse with `except_pc`=0x0000BFC0 while mem stall is high for 3 more cycles. A second `except_req` with `except_pc`=0x1234 arrives during PEND.
  - Response: `flush`=0 and `stall`=6'b011111 for 3 cycles. `flush`=1 with `new_pc`=0xBFC0 on the first cycle mem stall is low. The 0x1234 request is ignored.
- Watchdog with TIMEOUT=8: id stall held 7 cycles then released → `stall_timeout`=0 and `stall_cycles`=7. Hold 8 cycles → `stall_timeout`=1, and it stays 1 after the stall clears.
- Reset mid-PEND: enter PEND, assert `rst`=0 mid-cycle → state RUN and all counters 0 immediately. After release with no mem stall, `flush` is never asserted.
- Saturation: preload-equivalent run with CNT_W=4 and a continuous stall for 20 cycles → `stall_cycles`=15 and holds at 15.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Central pipeline control: merges per-stage stall requests into the stall vector,
// sequences exception flushes (deferred while MEM waits on the bus), and keeps debug statistics.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic             except_req,
  input  logic [31:0]      except_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [15:0]      flush_count,
  output logic             stall_timeout
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  typedef enum logic {RUN, PEND} state_t;

  state_t          state, state_nxt;
  logic [31:0]     pend_pc;
  logic            pend_latch;
  logic [WD_W-1:0] wd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      pend_pc <= '0;
    end else begin
      state <= state_nxt;
      if (pend_latch) pend_pc <= except_pc;
    end
  end

  // Exception arriving during a bus wait is parked; later exceptions are dropped until it flushes.
  always_comb begin
    state_nxt  = state;
    flush      = 1'b0;
    new_pc     = '0;
    pend_latch = 1'b0;
    unique case (state)
      RUN: begin
        if (except_req) begin
          if (stallreq_from_mem) begin
            pend_latch = 1'b1;
            state_nxt  = PEND;
          end else begin
            flush  = 1'b1;
            new_pc = except_pc;
          end
        end
      end
      PEND: begin
        if (!stallreq_from_mem) begin
          flush     = 1'b1;
          new_pc    = pend_pc;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    stall = '0;
    if (flush)                  stall = '0;
    else if (stallreq_from_mem) stall = 6'b011111;
    else if (stallreq_from_ex)  stall = 6'b001111;
    else if (stallreq_from_id)  stall = 6'b000111;
    else if (stallreq_from_if)  stall = 6'b000011;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles  <= '0;
      flush_count   <= '0;
      wd            <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (stall[0] && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (flush) flush_count <= flush_count + 16'd1;
      if (stall[0]) begin
        if (wd == WD_MAX) stall_timeout <= 1'b1;
        else              wd <= wd + 1'b1;
      end else begin
        wd <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_pipe_ctrl;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;
  localparam longint SC_MAX = (longint'(1) << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b0;
  logic             if_r = 1'b0, id_r = 1'b0, ex_r = 1'b0, mem_r = 1'b0;
  logic             exc = 1'b0;
  logic [31:0]      exc_pc = '0;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic [CNT_W-1:0] stall_cycles;
  logic [15:0]      flush_count;
  logic             stall_timeout;

  pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .stallreq_from_if(if_r), .stallreq_from_id(id_r),
    .stallreq_from_ex(ex_r), .stallreq_from_mem(mem_r),
    .except_req(exc), .except_pc(exc_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cycles(stall_cycles), .flush_count(flush_count),
    .stall_timeout(stall_timeout)
  );

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    longint      sc;
    int          fc;
    logic        to;
    int          id;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int step_id = 0;

  // Behavioural model: a pending-exception slot plus plain counters.
  bit          m_pending = 0;
  logic [31:0] m_pend_pc = '0;
  longint      m_total   = 0;
  int          m_flushes = 0;
  int          m_run     = 0;
  bit          m_to      = 0;

  task automatic model_reset();
    m_pending = 0; m_pend_pc = '0; m_total = 0; m_flushes = 0; m_run = 0; m_to = 0;
  endtask

  task automatic step(input bit r, input bit fi, input bit fd, input bit fe,
                      input bit fm, input bit e, input logic [31:0] p);
    exp_t x;
    int depth;
    @(posedge clk); #1;
    rst = r; if_r = fi; id_r = fd; ex_r = fe; mem_r = fm; exc = e; exc_pc = p;
    if (!r) model_reset();
    depth = fm ? 5 : fe ? 4 : fd ? 3 : fi ? 2 : 0;
    x.flush = 0; x.new_pc = '0;
    if (m_pending && !fm)            begin x.flush = 1; x.new_pc = m_pend_pc; end
    else if (!m_pending && e && !fm) begin x.flush = 1; x.new_pc = p; end
    x.stall = x.flush ? 6'd0 : 6'((1 << depth) - 1);
    x.sc = (m_total > SC_MAX) ? SC_MAX : m_total;
    x.fc = m_flushes;
    x.to = m_to;
    x.id = step_id++;
    sbq.push_back(x);
    if (r) begin
      if (!m_pending && e && fm) begin m_pending = 1; m_pend_pc = p; end
      else if (m_pending && !fm) m_pending = 0;
      if (x.stall[0]) begin
        m_total++; m_run++;
        if (m_run >= TIMEOUT) m_to = 1;
      end else m_run = 0;
      if (x.flush) m_flushes = (m_flushes + 1) % 65536;
    end
  endtask

  task automatic chk(input string name, input int id, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%0h required=0x%0h", name, id, act, req);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        chk("stall",         x.id, longint'(stall),         longint'(x.stall));
        chk("flush",         x.id, longint'(flush),         longint'(x.flush));
        chk("new_pc",        x.id, longint'(new_pc),        longint'(x.new_pc));
        chk("stall_cycles",  x.id, longint'(stall_cycles),  x.sc);
        chk("flush_count",   x.id, longint'(flush_count),   longint'(x.fc));
        chk("stall_timeout", x.id, longint'(stall_timeout), longint'(x.to));
      end
    end
  end

  initial begin : stim
    int guard;
    model_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    // priority ladder
    step(1, 1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // immediate flush overriding an id stall
    step(1, 0, 1, 0, 0, 1, 32'h0000_0380);
    step(1, 0, 0, 0, 0, 0, 0);
    // deferred flush; second exception during PEND is dropped
    step(1, 0, 0, 0, 1, 1, 32'h0000_BFC0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 1, 32'h0000_1234);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // watchdog: 7 stalled cycles do not trip it, 8 do, and the flag is sticky
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // reset in the middle of PEND discards the pending exception
    step(1, 0, 0, 0, 1, 1, 32'h0000_2000);
    step(1, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // saturation of stall_cycles
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // random traffic
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) >= 2),
           1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 40),
           ($urandom_range(0, 99) < 15), $urandom());
    guard = 0;
    while (sbq.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
